// File: rtl/aes_pkg.sv
// Shared AES-128 key schedule definitions: round count, round constants,
// controller state encoding and the round key container type.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  // Index 0 is unused padding so RCON[r] lines up with round number r.
  localparam logic [10:0][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
  };

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  typedef logic [127:0] key128_t;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    return (r <= 4'd10) ? RCON[r] : 8'h00;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box; byte 0x00 maps to the top byte of the table.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry i sits at bit offset (255 - i) * 8, and 255 - i is simply ~i.
  assign dout = TBL[{~din, 3'b000} +: 8];

endmodule

// File: rtl/inv_key_expand.sv
// Inverse AES-128 key schedule: loads the last round key word by word, then
// walks backwards one round key per cycle down to the cipher key.
module inv_key_expand #(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [31:0] key_word,
  input  logic [3:0]  round_key_n,
  input  logic [1:0]  r_index,
  output logic [31:0] round_key,
  output logic        busy,
  output logic        done
);
  import aes_pkg::*;

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  state_t     state;
  logic [2:0] load_cnt;
  logic [3:0] r;
  key128_t    rk [0:NUM_ROUNDS];

  key128_t     cur_key, next_key;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] w1n, w2n, w3n, rot_w, sub_w;

  always_comb begin
    cur_key = '0;
    if (r <= LAST) cur_key = rk[r];
  end

  assign {w0, w1, w2, w3} = cur_key;
  assign w3n   = w3 ^ w2;
  assign w2n   = w2 ^ w1;
  assign w1n   = w1 ^ w0;
  assign rot_w = {w3n[23:0], w3n[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (rot_w[8*i +: 8]),
      .dout (sub_w[8*i +: 8])
    );
  end

  assign next_key = {w0 ^ sub_w ^ {rcon(r), 24'h0}, w1n, w2n, w3n};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      load_cnt <= '0;
      r        <= '0;
      done     <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load_valid) begin
            rk[LAST][127:96] <= key_word;
            done             <= 1'b0;
            load_cnt         <= 3'd1;
            state            <= LOAD;
          end
        end
        LOAD: begin
          // Once all four words are in, spend one cycle handing over to EXPAND.
          if (load_cnt == 3'd4) begin
            state <= EXPAND;
          end else if (load_valid) begin
            case (load_cnt[1:0])
              2'd1:    rk[LAST][95:64] <= key_word;
              2'd2:    rk[LAST][63:32] <= key_word;
              default: rk[LAST][31:0]  <= key_word;
            endcase
            load_cnt <= load_cnt + 3'd1;
            if (load_cnt == 3'd3) r <= LAST;
          end
        end
        EXPAND: begin
          rk[r - 4'd1] <= next_key;
          r            <= r - 4'd1;
          if (r == 4'd1) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == LOAD) || (state == EXPAND);

  always_comb begin
    round_key = '0;
    if (done && (round_key_n <= LAST)) round_key = rk[round_key_n][{r_index, 5'b0} +: 32];
  end

endmodule

// File: tb/tb_inv_key_expand.sv
// Directed bench for inv_key_expand using the FIPS-197 AES-128 key schedule.
module tb_inv_key_expand;

  logic        clk = 1'b0;
  logic        reset, load_valid;
  logic [31:0] key_word;
  logic [3:0]  round_key_n;
  logic [1:0]  r_index;
  logic [31:0] round_key;
  logic        busy, done;

  int checks   = 0;
  int failures = 0;

  logic [31:0]  exp_q [$];
  logic [127:0] fips_rk [0:10];

  inv_key_expand dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .key_word    (key_word),
    .round_key_n (round_key_n),
    .r_index     (r_index),
    .round_key   (round_key),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_key(input logic [3:0] n, input logic [1:0] idx,
                          input logic [31:0] exp, input string tag);
    @(negedge clk);
    round_key_n = n;
    r_index     = idx;
    exp_q.push_back(exp);
    #1;
    check($sformatf("%s_n%0d_i%0d", tag, n, idx), round_key, exp_q.pop_front());
  endtask

  task automatic verify_fips(input string tag);
    for (int n = 0; n <= 10; n++)
      for (int i = 3; i >= 0; i--)
        read_key(4'(n), 2'(i), fips_rk[n][i*32 +: 32], tag);
    read_key(4'd11, 2'd3, 32'h0, {tag, "_oor11"});
    read_key(4'd15, 2'd0, 32'h0, {tag, "_oor15"});
  endtask

  // Drives words MSB first following the valid pattern (bit k = cycle k).
  task automatic load_key(input logic [127:0] key, input logic [7:0] pat,
                          input int plen, input string tag);
    int j = 0;
    for (int k = 0; k < plen; k++) begin
      @(negedge clk);
      load_valid = pat[k];
      key_word   = pat[k] ? key[127 - 32*j -: 32] : $urandom();
      @(posedge clk);
      #1;
      if (pat[k]) j++;
      if (j == 1 && pat[k]) check({tag, "_done_clear"}, 32'(done), 32'd0);
      if (j >= 1) check($sformatf("%s_busy_c%0d", tag, k), 32'(busy), 32'd1);
    end
  endtask

  // Counts edges after the 4th word was accepted until done rises.
  task automatic wait_done(input bit noise, input string tag);
    int k = 0;
    while (k < 20) begin
      @(negedge clk);
      load_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      key_word   = $urandom();
      @(posedge clk);
      #1;
      k++;
      if (done) break;
    end
    check({tag, "_latency"}, 32'(k), 32'd11);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  initial begin
    logic [127:0] k10;
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    k10 = fips_rk[10];

    reset = 1'b1; load_valid = 1'b0; key_word = '0; round_key_n = '0; r_index = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    read_key(4'd0, 2'd3, 32'h0, "rst_rk");
    @(negedge clk);
    reset = 1'b0;

    load_key(k10, 8'h0f, 4, "plain");
    wait_done(1'b0, "plain");
    verify_fips("plain");
    read_key(4'd10, 2'd3, 32'hd014f9a8, "k10_top");

    load_key(k10, 8'b0011_0101, 6, "gaps");
    wait_done(1'b0, "gaps");
    verify_fips("gaps");

    load_key(k10, 8'h0f, 4, "noise");
    wait_done(1'b1, "noise");
    verify_fips("noise");

    load_key(k10, 8'h0f, 4, "midrst");
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; load_valid = 1'b1; key_word = 32'hdeadbeef;
    @(posedge clk);
    #1;
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    read_key(4'd0, 2'd3, 32'h0, "midrst_rk");
    @(negedge clk);
    reset = 1'b0; load_valid = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_idle_busy", 32'(busy), 32'd0);
    load_key(k10, 8'h0f, 4, "afterrst");
    wait_done(1'b0, "afterrst");
    verify_fips("afterrst");

    load_key(128'h0, 8'h0f, 4, "zero");
    wait_done(1'b0, "zero");
    check("zero_done", 32'(done), 32'd1);
    for (int i = 3; i >= 0; i--) read_key(4'd10, 2'(i), 32'h0, "zero_k10");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inv_key_expand.md
INV_KEY_EXPAND -- requirements
Module: inv_key_expand

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: port names clk and reset; polarity and synchronicity are fixed.
REQ-002 Parameter NUM_ROUNDS: default 10; number of AES-128 rounds, held fixed.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 load_valid  in  1  qualifies key_word for the current cycle.
REQ-006 key_word  in  32  one word of round key 10; MSB word (bits 127:96) first.
REQ-007 round_key_n  in  4  selects the round key to read, 0..10.
REQ-008 r_index  in  2  selects a 32-bit slice: bits [r_index*32 +: 32].
REQ-009 round_key  out  32  selected slice of the stored round key.
REQ-010 busy  out  1  high in states LOAD and EXPAND.
REQ-011 done  out  1  high when all 11 round keys are valid.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, EXPAND and DONE.
REQ-013 IDLE or DONE with load_valid=1: SHALL capture key_word into bits [127:96] of the round key 10 register, clear done, set load count to 1, and go to LOAD.
REQ-014 LOAD: each cycle with load_valid=1 SHALL store key_word into the next lower word; cycles with load_valid=0 SHALL hold all state.
REQ-015 LOAD: when the 4th word is accepted, SHALL set round counter r=10 and go to EXPAND on the next edge.
REQ-016 EXPAND: each cycle SHALL compute K[r-1] from K[r] and write it to entry r-1, then decrement r. With K[r]=(w0,w1,w2,w3), w0 MSB:
  - w3' = w3^w2
  - w2' = w2^w1
  - w1' = w1^w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {RCON[r],24'h0}
REQ-017 RCON[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36 (hex).
REQ-018 RotWord SHALL rotate left by one byte; SubWord SHALL apply the AES S-box to each byte.
REQ-019 EXPAND SHALL last exactly NUM_ROUNDS cycles; after entry 0 is written, the FSM SHALL go to DONE and set done=1.
REQ-020 Latency: done SHALL rise 11 cycles after the edge that accepts the 4th word, provided there is no reset.
REQ-021 load_valid during EXPAND SHALL be ignored; no words are dropped into the key registers.
REQ-022 DONE SHALL hold done=1 and all entries until a new load or reset.
REQ-023 round_key SHALL be combinational from round_key_n and r_index when done=1.
REQ-024 round_key SHALL be 0 when done=0 or round_key_n>10.
REQ-025 A new load from DONE SHALL clear done in the same edge that accepts word 0; entries 0..9 become invalid.

Reset
REQ-026 reset=1 at any clock edge, including mid-LOAD or mid-EXPAND, SHALL force:
  - state to IDLE
  - load count and r to 0
  - all 11 round key registers to 0
  - busy=0, done=0, round_key=0
REQ-027 reset SHALL take priority over load_valid in the same cycle.

Structure
REQ-028 Package aes_pkg SHALL hold:
  - the NUM_ROUNDS constant
  - the RCON table
  - the FSM state enum typedef
  - the 128-bit round key typedef
REQ-029 The S-box SHALL be a sub-module aes_sbox (8-bit in, 8-bit out, combinational), instantiated 4 times.

Verification
REQ-030 FIPS-197 vector: load d014f9a8, c9ee2589, e13f0cc8, b6630ca6 -> done after 11 cycles.
  - round_key_n=0, r_index=3 -> 2b7e1516
  - round_key_n=0, r_index=0 -> 09cf4f3c
REQ-031 Same load; round_key_n=1, r_index=3..0 -> a0fafe17, 88542cb1, 23a33939, 2a6c7605.
REQ-032 Load with load_valid gaps (pattern 1,0,1,0,1,1) -> the same results as REQ-030; busy stays high through the gaps.
REQ-033 reset asserted 5 cycles into EXPAND -> next cycle: done=0, busy=0, round_key=0; a fresh load then completes correctly.
REQ-034 Edge and out-of-range reads:
  - load_valid pulses during EXPAND -> results unchanged
  - round_key_n=11 in DONE -> round_key=0
  - round_key_n=10 in DONE -> loaded key, e.g. r_index=3 -> d014f9a8
REQ-035 Reload from DONE with an all-zero key -> done drops on the first accepted word; done rises again and round_key_n=10 reads 0.
